// File: rtl/uart_tx_mmio_if.sv
// uart_tx_mmio_if: CPU data-port signals seen by the memory-mapped UART transmitter
interface uart_tx_mmio_if;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        we;
   logic [31:0] rdata;
   logic        hit;
   modport master (output addr, wdata, we, input rdata, hit);
   modport slave (input addr, wdata, we, output rdata, hit);
endinterface

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with TX FIFO and combinational status read
module uart_tx_mmio #(
   parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
   parameter int          CLKS_PER_BIT = 868,
   parameter int          FIFO_DEPTH   = 8
) (
   input  logic           clk,
   input  logic           n_reset,
   uart_tx_mmio_if.slave  bus,
   output logic           txd
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [31:0] ST_ADDR = BASE_ADDR + 32'd4;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t        state_q, state_d;
   logic [CW-1:0] baud_q, baud_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [AW-1:0] rptr_q, wptr_q;
   logic [AW:0]   count_q, count_d;
   logic          ovf_q;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic          hit_tx, hit_st, empty, full, tick, pop, push, accept, ovf_clr;
   logic          unused_ok;
   assign hit_tx    = bus.addr[31:2] == BASE_ADDR[31:2];
   assign hit_st    = bus.addr[31:2] == ST_ADDR[31:2];
   assign bus.hit   = hit_tx | hit_st;
   assign empty     = count_q == '0;
   assign full      = count_q == (AW+1)'(FIFO_DEPTH);
   assign bus.rdata = hit_st ? {16'h0, 8'(count_q), 4'h0, ovf_q, empty, full, state_q != IDLE} : '0;
   assign tick      = baud_q == CW'(CLKS_PER_BIT - 1);
   assign push      = bus.we & hit_tx;
   // a full FIFO still accepts when the head leaves at the same edge
   assign accept    = push & (~full | pop);
   assign ovf_clr   = bus.we & hit_st & bus.wdata[3];
   assign count_d   = count_q + (AW+1)'(accept) - (AW+1)'(pop);
   assign txd       = state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : 1'b1;
   assign unused_ok = ^{bus.wdata[31:8], bus.addr[1:0]};
   always_comb begin
      state_d = state_q;
      baud_d  = tick ? '0 : baud_q + 1'b1;
      idx_d   = idx_q;
      shift_d = shift_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            baud_d = '0;
            if (!empty) begin
               pop     = 1'b1;
               shift_d = mem_q[rptr_q];
               state_d = START;
            end
         end
         START: if (tick) begin
            state_d = DATA;
            idx_d   = '0;
         end
         DATA: if (tick) begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + 1'b1;
            if (idx_q == 3'd7) state_d = STOP;
         end
         STOP: if (tick) begin
            if (!empty) begin
               pop     = 1'b1;
               shift_d = mem_q[rptr_q];
               state_d = START;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q <= IDLE;
         baud_q  <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         count_q <= count_d;
         ovf_q   <= (ovf_q & ~ovf_clr) | (push & ~accept);
         if (accept) wptr_q <= wptr_q + 1'b1;
         if (pop) rptr_q <= rptr_q + 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (accept) mem_q[wptr_q] <= bus.wdata[7:0];
   end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: randomized self-checking bench against a queue/frame-position reference model
module tb_uart_tx_mmio;
   localparam logic [31:0] BASE = 32'h1000_0000;
   localparam logic [31:0] ST   = 32'h1000_0004;
   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;
   logic clk = 1'b0;
   logic n_reset = 1'b0;
   logic txd;
   uart_tx_mmio_if bus();
   uart_tx_mmio #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .n_reset(n_reset), .bus(bus), .txd(txd)
   );
   always #5 clk = ~clk;
   int checks = 0;
   int errors = 0;
   logic [7:0] q[$];
   int pos = -1;
   logic [7:0] cur = 8'h0;
   logic ovf = 1'b0;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask
   function automatic logic is_tx(input logic [31:0] a);
      return a[31:2] == BASE[31:2];
   endfunction
   function automatic logic is_st(input logic [31:0] a);
      return a[31:2] == ST[31:2];
   endfunction
   function automatic logic [31:0] exp_rdata(input logic [31:0] a);
      if (is_st(a)) return {16'h0, 8'(q.size()), 4'h0, ovf, q.size() == 0, q.size() == DEPTH, pos >= 0};
      return 32'h0;
   endfunction
   function automatic logic exp_txd();
      logic [9:0] fr;
      fr = {1'b1, cur, 1'b0};
      return pos < 0 ? 1'b1 : fr[pos / CPB];
   endfunction
   task automatic model(input logic w, input logic [31:0] a, input logic [31:0] d);
      bit pop = q.size() != 0 && (pos < 0 || pos == FRAME - 1);
      bit req = w && is_tx(a);
      bit acc = req && (q.size() < DEPTH || pop);
      if (w && is_st(a) && d[3]) ovf = 1'b0;
      if (req && !acc) ovf = 1'b1;
      if (pos >= 0) pos++;
      if (pos == FRAME) pos = -1;
      if (pop) begin
         cur = q.pop_front();
         pos = 0;
      end
      if (acc) q.push_back(d[7:0]);
   endtask
   task automatic model_reset();
      q.delete();
      pos = -1;
      ovf = 1'b0;
   endtask
   task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d);
      bus.we = w;
      bus.addr = a;
      bus.wdata = d;
      #1;
      chk("txd", {31'h0, txd}, {31'h0, exp_txd()});
      chk("hit", {31'h0, bus.hit}, {31'h0, is_tx(a) | is_st(a)});
      chk("rdata", bus.rdata, exp_rdata(a));
      @(posedge clk);
      model(w, a, d);
      @(negedge clk);
   endtask
   task automatic idle(input int n);
      repeat (n) step(1'b0, ST, 32'h0);
   endtask
   task automatic drain();
      int n = 0;
      while ((pos >= 0 || q.size() != 0) && n < 2000) begin
         step(1'b0, ST, 32'h0);
         n++;
      end
      idle(2);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end
   initial begin
      int n;
      logic [31:0] a, d;
      logic w;
      bus.we = 1'b0;
      bus.addr = ST;
      bus.wdata = 32'h0;
      @(negedge clk);
      #1;
      chk("rst_status", bus.rdata, 32'h0000_0004);
      chk("rst_hit", {31'h0, bus.hit}, 32'h1);
      chk("rst_txd", {31'h0, txd}, 32'h1);
      @(negedge clk);
      n_reset = 1'b1;
      step(1'b0, ST, 32'h0);
      step(1'b0, 32'h0000_0040, 32'h0);
      step(1'b1, BASE, 32'hA5);
      idle(45);
      step(1'b1, BASE, 32'h01);
      step(1'b1, BASE, 32'h02);
      step(1'b1, BASE, 32'h03);
      idle(125);
      for (int i = 0; i < 6; i++) step(1'b1, BASE, $urandom);
      bus.we = 1'b0;
      bus.addr = ST;
      #1;
      chk("t4_status", bus.rdata, 32'h0000_040B);
      step(1'b1, ST, 32'h8);
      n = 0;
      while (!(pos == FRAME - 1 && q.size() == DEPTH) && n < 200) begin
         step(1'b0, ST, 32'h0);
         n++;
      end
      step(1'b1, BASE, $urandom);
      bus.we = 1'b0;
      bus.addr = ST;
      #1;
      chk("t5_status", bus.rdata, 32'h0000_0403);
      drain();
      for (int i = 0; i < 900; i++) begin
         n = $urandom_range(0, 9);
         d = $urandom;
         a = n < 4 ? (BASE | 32'($urandom_range(0, 3))) : n < 6 ? ST : n < 7 ? BASE + 32'd8 : $urandom;
         w = $urandom_range(0, 9) < 3;
         step(w, a, d);
      end
      drain();
      for (int i = 0; i < 3; i++) step(1'b1, BASE, 32'h0);
      n = 0;
      while (pos != 15 && n < 200) begin
         step(1'b0, ST, 32'h0);
         n++;
      end
      bus.addr = ST;
      bus.we = 1'b0;
      n_reset = 1'b0;
      #1;
      model_reset();
      chk("t6_txd", {31'h0, txd}, 32'h1);
      chk("t6_status", bus.rdata, 32'h0000_0004);
      #1;
      n_reset = 1'b1;
      @(negedge clk);
      idle(60);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
